serial_subtractor: RTL

- Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- A single full-subtractor cell feeds a borrow flop. This is the sequential, inverse-operation counterpart to the combinational ripple adder chain.
- Used where area matters more than latency and where operands arrive via a start/done handshake from a controller.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit needs a borrow.
// Purely combinational so it can also be chained into a ripple subtractor.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are captured on an accepted start, shifted through a single
// full-subtractor cell, and the result is published with a one-cycle done.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   r_reg;
   logic [WIDTH-1:0]   diff_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               brw_reg;
   logic               bout_reg;

   logic [WIDTH-1:0]   a_next;
   logic [WIDTH-1:0]   b_next;
   logic [WIDTH-1:0]   r_next;
   logic               d_bit;
   logic               brw_next;

   // The single arithmetic cell works on the current LSBs and the borrow flop.
   full_subtractor u_fs (
      .x  (a_reg[0]),
      .y  (b_reg[0]),
      .bi (brw_reg),
      .d  (d_bit),
      .bo (brw_next)
   );

   // Operands shift right toward the cell; result bits enter at the MSB end.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_next[gi] = a_reg[gi+1];
         assign b_next[gi] = b_reg[gi+1];
         assign r_next[gi] = r_reg[gi+1];
      end
   endgenerate
   assign a_next[WIDTH-1] = 1'b0;
   assign b_next[WIDTH-1] = 1'b0;
   assign r_next[WIDTH-1] = d_bit;

   // Controller, datapath registers and published result in one sequential block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         r_reg     <= '0;
         brw_reg   <= 1'b0;
         cnt_reg   <= '0;
         diff_reg  <= '0;
         bout_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  brw_reg   <= bin;
                  cnt_reg   <= '0;
                  r_reg     <= '0;
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               a_reg   <= a_next;
               b_reg   <= b_next;
               r_reg   <= r_next;
               brw_reg <= brw_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               // Last bit: publish the full word and the final borrow together.
               if (cnt_reg == LAST_CNT) begin
                  diff_reg  <= r_next;
                  bout_reg  <= brw_next;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign diff = diff_reg;
   assign bout = bout_reg;

endmodule : serial_subtractor
